// File: rtl/sha2_pkg.sv
// Shared types, sigma rotation constants and sigma helpers for the SHA-2 message
// schedule expander.
package sha2_pkg;

  typedef enum logic {LOAD = 1'b0, EXPAND = 1'b1} state_e;

  localparam int IDX_W = 7;

  localparam int S0_256_A = 7;
  localparam int S0_256_B = 18;
  localparam int S0_256_S = 3;
  localparam int S1_256_A = 17;
  localparam int S1_256_B = 19;
  localparam int S1_256_S = 10;
  localparam int S0_512_A = 1;
  localparam int S0_512_B = 8;
  localparam int S0_512_S = 7;
  localparam int S1_512_A = 19;
  localparam int S1_512_B = 61;
  localparam int S1_512_S = 6;

  function automatic int rounds_for(input int word_width);
    return (word_width == 32) ? 64 : 80;
  endfunction

  function automatic logic [31:0] rotr32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [63:0] rotr64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [31:0] ssig0_256(input logic [31:0] x);
    return rotr32(x, S0_256_A) ^ rotr32(x, S0_256_B) ^ (x >> S0_256_S);
  endfunction

  function automatic logic [31:0] ssig1_256(input logic [31:0] x);
    return rotr32(x, S1_256_A) ^ rotr32(x, S1_256_B) ^ (x >> S1_256_S);
  endfunction

  function automatic logic [63:0] ssig0_512(input logic [63:0] x);
    return rotr64(x, S0_512_A) ^ rotr64(x, S0_512_B) ^ (x >> S0_512_S);
  endfunction

  function automatic logic [63:0] ssig1_512(input logic [63:0] x);
    return rotr64(x, S1_512_A) ^ rotr64(x, S1_512_B) ^ (x >> S1_512_S);
  endfunction

endpackage

// File: rtl/sha2_message_scheduler_if.sv
// Stream bundle between block padder, schedule expander and round engine.
interface sha2_message_scheduler_if #(parameter int WORD_WIDTH = 32);
  import sha2_pkg::*;

  logic [WORD_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [WORD_WIDTH-1:0] out_data;
  logic [IDX_W-1:0]      out_index;
  logic                  out_last;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_index, out_last, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_index, out_last, out_valid
  );

endinterface

// File: rtl/sha2_sched_word.sv
// Combinational next-schedule-word: Wn = ssig1(W[t-2]) + W[t-7] + ssig0(W[t-15]) + W[t-16].
module sha2_sched_word
  import sha2_pkg::*;
#(
  parameter int WORD_WIDTH = 32
) (
  input  logic [WORD_WIDTH-1:0] i_w0,
  input  logic [WORD_WIDTH-1:0] i_w1,
  input  logic [WORD_WIDTH-1:0] i_w9,
  input  logic [WORD_WIDTH-1:0] i_w14,
  output logic [WORD_WIDTH-1:0] o_wn
);

  if (WORD_WIDTH == 32) begin : g_w32
    assign o_wn = ssig1_256(i_w14) + i_w9 + ssig0_256(i_w1) + i_w0;
  end else begin : g_w64
    assign o_wn = ssig1_512(i_w14) + i_w9 + ssig0_512(i_w1) + i_w0;
  end

endmodule

// File: rtl/sha2_message_scheduler.sv
// Streaming SHA-2 message-schedule expander: 16 words in, ROUNDS schedule words out,
// one per cycle, through a single registered output slot.
module sha2_message_scheduler
  import sha2_pkg::*;
#(
  parameter int WORD_WIDTH = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic abort,
  sha2_message_scheduler_if.slave s_if,
  output logic busy
);

  localparam int              ROUNDS   = rounds_for(WORD_WIDTH);
  localparam logic [IDX_W-1:0] LOAD_END = IDX_W'(15);
  localparam logic [IDX_W-1:0] LAST_T   = IDX_W'(ROUNDS - 1);

  if (WORD_WIDTH != 32 && WORD_WIDTH != 64) begin : g_bad_width
    $error("sha2_message_scheduler: WORD_WIDTH must be 32 or 64");
  end

  state_e                r_state;
  state_e                w_state_nxt;
  logic [IDX_W-1:0]      r_t;
  logic [WORD_WIDTH-1:0] r_win [16];
  logic [WORD_WIDTH-1:0] r_out_data;
  logic [IDX_W-1:0]      r_out_index;
  logic                  r_out_last;
  logic                  r_out_valid;

  logic                  w_slot_free;
  logic                  w_load_fire;
  logic                  w_exp_fire;
  logic                  w_fire;
  logic                  w_last_round;
  logic [WORD_WIDTH-1:0] w_wn;
  logic [WORD_WIDTH-1:0] w_new_word;

  sha2_sched_word #(.WORD_WIDTH(WORD_WIDTH)) u_word (
    .i_w0  (r_win[0]),
    .i_w1  (r_win[1]),
    .i_w9  (r_win[9]),
    .i_w14 (r_win[14]),
    .o_wn  (w_wn)
  );

  assign w_slot_free  = !r_out_valid || s_if.out_ready;
  assign w_last_round = (r_state == EXPAND) && (r_t == LAST_T);
  assign w_fire       = w_load_fire || w_exp_fire;
  assign w_new_word   = (r_state == LOAD) ? s_if.in_data : w_wn;

  always_comb begin
    w_state_nxt = r_state;
    w_load_fire = 1'b0;
    w_exp_fire  = 1'b0;
    case (r_state)
      LOAD: begin
        w_load_fire = s_if.in_valid && w_slot_free;
        if (w_load_fire && (r_t == LOAD_END)) w_state_nxt = EXPAND;
      end
      EXPAND: begin
        w_exp_fire = w_slot_free;
        if (w_exp_fire && (r_t == LAST_T)) w_state_nxt = LOAD;
      end
      default: w_state_nxt = LOAD;
    endcase
  end

  // Control state: abort flushes the block but leaves the window contents alone
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      r_state     <= LOAD;
      r_t         <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_fire) r_t <= w_last_round ? '0 : r_t + 1'b1;
      if (w_slot_free) begin
        r_out_valid <= w_fire;
        r_out_last  <= w_fire && w_last_round;
      end
    end
  end

  // Window shift and output data slot
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) r_win[i] <= '0;
      r_out_data  <= '0;
      r_out_index <= '0;
    end else if (!abort && w_fire) begin
      for (int i = 0; i < 15; i++) r_win[i] <= r_win[i+1];
      r_win[15]   <= w_new_word;
      r_out_data  <= w_new_word;
      r_out_index <= r_t;
    end
  end

  assign s_if.in_ready  = (r_state == LOAD) && w_slot_free;
  assign s_if.out_data  = r_out_data;
  assign s_if.out_index = r_out_index;
  assign s_if.out_last  = r_out_last;
  assign s_if.out_valid = r_out_valid;

  assign busy = (r_state == EXPAND) || (r_t != '0) || (r_out_valid && !r_out_last);

endmodule
